tff_counter_ctrl: RTL
=====================

# tff_counter_ctrl

Sequencing controller for a bank of T flip-flops used as a programmable modulo counter. Each cycle it computes the toggle vector for the flop bank so the bank performs one of these operations: count up, count down, wrap at a run-time modulus, load a value, or hold. It also supports free-running and one-shot modes. It sits between the lab's control/switch logic and the T-flop register, and is the single owner of every T input in the bank.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (1..16)

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  reset, synchronous and active-high
- start  in  1  pulse; enter RUN (from IDLE or DONE)
- stop  in  1  pulse; return to IDLE, count held
- up  in  1  direction: 1 = up, 0 = down; sampled every cycle
- one_shot  in  1  1 = stop at terminal count; sampled in RUN
- load  in  1  pulse; load load_val on the next edge
- load_val  in  WIDTH  value to load
- modulus  in  WIDTH  highest count value; count range is 0..modulus
- count  out  WIDTH  Q of the flop bank
- t_vec  out  WIDTH  toggle vector driven into the bank (combinational)
- tc  out  1  terminal-count strobe (combinational)
- running  out  1  state == RUN
- done  out  1  state == DONE

## Operation
- Flop bank update: Q_next = Q ^ t_vec. All count changes are expressed only as toggle vectors.
- FSM states: IDLE, RUN, DONE.
- Reset: state becomes IDLE and the bank clears to 0. After reset, count, t_vec, tc, running and done are all 0.
- Command priority: rst > load > stop > start > counting.
- load (any state): t_vec = Q ^ min(load_val, modulus). State is unchanged, except DONE goes to IDLE.
- stop: t_vec = 0; next state IDLE.
- start in IDLE: go to RUN; no toggle on this edge.
- start in DONE: go to RUN and reset the count to the start value (0 when up, modulus when down).
- Terminal condition: up and (count >= modulus), or down and (count == 0).
- RUN, not at terminal:
  - up: t_vec[i] = &Q[i-1:0]
  - down: t_vec[i] = &(~Q[i-1:0])
  - t_vec[0] = 1 in both directions.
- RUN, at terminal:
  - tc = 1.
  - If one_shot = 0: wrap. Up gives t_vec = Q (next count 0). Down gives t_vec = Q ^ modulus (next count modulus).
  - If one_shot = 1: t_vec = 0 and next state DONE; count holds at the terminal value.
- IDLE and DONE: t_vec = 0 and tc = 0, unless load is active.
- modulus = 0: count stays 0, and tc = 1 on every RUN cycle (or DONE on the first cycle if one_shot).
- modulus lowered below the current count while counting up: the next edge wraps to 0 and tc = 1 in that cycle.
- Direction change takes effect on the same cycle's t_vec; no extra states.

## Timing
- count changes only on rising edges of clk. There is one edge of latency from a command to the new count.
- t_vec and tc are combinational from state, Q, and inputs in the same cycle. tc is high in the cycle before the wrap edge.
- running and done are registered state decodes; they change on the edge after start/stop/terminal.
- rst asserted mid-run clears everything on that edge and overrides a simultaneous load or start.
- load together with start in IDLE: the load is applied and state stays IDLE. start must be re-issued.
- No handshake back-pressure. Commands are single-cycle pulses; levels held longer repeat the command each cycle.

## Structure
- tff_ctrl_pkg: state enum (IDLE, RUN, DONE) and the function t_up(Q)/t_down(Q) computing the prefix-AND toggle vectors.
- One sub-module, t_reg: WIDTH T-type flops with synchronous active-high rst, input t_vec, output Q.
- The controller contains the FSM, terminal compare, and t_vec mux.

## Test plan
- Reset: assert rst for 2 cycles with start = 1 → count = 0, running = 0, done = 0, tc = 0.
- Free-run up, WIDTH = 4, modulus = 9: start → count follows 0,1,…,9,0. tc = 1 only during count = 9; t_vec = 4'b1001 at 9→0.
- Down one-shot, modulus = 5, load 3: count 3,2,1,0 then holds. tc = 1 in one cycle, done = 1, running = 0. A later start → count = 5, RUN.
- Load clamp: modulus = 6, load_val = 12 → count = 6 on the next edge. With load and stop in the same cycle, load wins and the state becomes IDLE.
- Modulus lowered mid-run: counting up at 8, set modulus = 3 → next count 0 with tc = 1 in that cycle, then 1,2,3,0.
- Mid-run rst, and up/down flip: at count 7 toggle up = 0 → next count 6. rst at count 6 → count 0 and IDLE on the same edge.

Source files
------------

// File: rtl/tff_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tff_ctrl_pkg
// Shared definitions for the T-flop modulo counter controller.
//   state_t : controller FSM states (IDLE, RUN, DONE)
//   MAX_W   : widest bank the helper functions support
//   t_up    : toggle vector that advances a binary count by one
//   t_down  : toggle vector that retreats a binary count by one
// ---------------------------------------------------------------------------
package tff_ctrl_pkg;

    localparam int MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit i toggles when every lower bit is 1 (carry ripples through it).
    function automatic logic [MAX_W-1:0] t_up(input logic [MAX_W-1:0] q);
        logic [MAX_W-1:0] t;
        logic             carry;
        carry = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
            t[i]  = carry;
            carry = carry & q[i];
        end
        return t;
    endfunction

    // Bit i toggles when every lower bit is 0 (borrow ripples through it).
    function automatic logic [MAX_W-1:0] t_down(input logic [MAX_W-1:0] q);
        logic [MAX_W-1:0] t;
        logic             borrow;
        borrow = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
            t[i]   = borrow;
            borrow = borrow & ~q[i];
        end
        return t;
    endfunction

endpackage

// File: rtl/tff_counter_ctrl_t_reg.sv
// ---------------------------------------------------------------------------
// t_reg
// Bank of WIDTH T-type flip-flops: q <= q ^ t on each rising edge.
//   clk : rising-edge clock
//   rst : synchronous active-high clear of the whole bank
//   t   : per-bit toggle enables
//   q   : flop outputs
// ---------------------------------------------------------------------------
module t_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/tff_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tff_counter_ctrl
// Sequencing controller for a T-flop modulo counter. Every count change is
// expressed as a toggle vector into the flop bank (count_next = count ^ t_vec).
// Supports count up/down, wrap at a run-time modulus, load, hold, and
// free-running or one-shot operation.
//   clk, rst  : clock and synchronous active-high reset
//   start     : enter RUN from IDLE, or restart from DONE
//   stop      : return to IDLE, count held
//   up        : 1 = count up, 0 = count down
//   one_shot  : 1 = stop in DONE at terminal count instead of wrapping
//   load      : load min(load_val, modulus) on the next edge
//   load_val  : value to load
//   modulus   : highest count value (range is 0..modulus)
//   count     : flop bank Q
//   t_vec     : toggle vector into the bank (combinational)
//   tc        : terminal-count strobe (combinational)
//   running   : registered state == RUN
//   done      : registered state == DONE
// ---------------------------------------------------------------------------
module tff_counter_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             up,
    input  logic             one_shot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] t_vec,
    output logic             tc,
    output logic             running,
    output logic             done
);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   load_clamped;
    logic [MAX_W-1:0]   t_up_full;
    logic [MAX_W-1:0]   t_down_full;
    logic [WIDTH-1:0]   t_cnt_up;
    logic [WIDTH-1:0]   t_cnt_down;
    logic               at_term;

    t_reg #(
        .WIDTH (WIDTH)
    ) u_t_reg (
        .clk (clk),
        .rst (rst),
        .t   (t_vec),
        .q   (count)
    );

    assign t_up_full    = t_up(MAX_W'(count));
    assign t_down_full  = t_down(MAX_W'(count));
    assign t_cnt_up     = t_up_full[WIDTH-1:0];
    assign t_cnt_down   = t_down_full[WIDTH-1:0];
    assign load_clamped = (load_val > modulus) ? modulus : load_val;

    // ">=" on the up side lets a modulus lowered below the count wrap at once.
    assign at_term = up ? (count >= modulus) : (count == '0);

    always_comb begin
        state_next = state;
        t_vec      = '0;
        tc         = 1'b0;

        if (load) begin
            t_vec = count ^ load_clamped;
            // A simultaneous stop still parks the FSM; a load also releases DONE.
            if (stop || state == DONE) begin
                state_next = IDLE;
            end
        end else if (stop) begin
            state_next = IDLE;
        end else if (start && state != RUN) begin
            state_next = RUN;
            // Restart from DONE rewinds to the direction's start value.
            if (state == DONE) begin
                t_vec = up ? count : (count ^ modulus);
            end
        end else if (state == RUN) begin
            if (at_term) begin
                tc = 1'b1;
                if (one_shot) begin
                    state_next = DONE;
                end else begin
                    t_vec = up ? count : (count ^ modulus);
                end
            end else begin
                t_vec = up ? t_cnt_up : t_cnt_down;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == RUN);
            done    <= (state_next == DONE);
        end
    end

endmodule
